// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, 8N1 framing levels and the
// bit-period derivation used by both the packet transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned UartDataBits  = 8;
    localparam logic        UartStartBit  = 1'b0;
    localparam logic        UartStopBit   = 1'b1;
    localparam logic        UartIdleLevel = 1'b1;

    // Integer division: the bit period truncates toward zero.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte serializer. A start request seen in IDLE, or at the last cycle of
// a stop bit, loads the next byte so consecutive bytes follow with no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [UartDataBits-1:0] byte_i,
    output logic                    tx_o,
    output logic                    byte_done_o
);

    localparam int unsigned    CntW    = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
    localparam logic [2:0]     LastBit = 3'(UartDataBits - 1);

    tx_state_e               state_q, state_d;
    logic [CntW-1:0]         baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic                    bit_end;

    assign bit_end = (baud_q == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StStart;
                    shift_d = byte_i;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (start_i) begin
                        state_d = StStart;
                        shift_d = byte_i;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_o        = UartIdleLevel;
        byte_done_o = (state_q == StStop) && bit_end;
        unique case (state_q)
            StIdle:  tx_o = UartIdleLevel;
            StStart: tx_o = UartStartBit;
            StData:  tx_o = shift_q[0];
            StStop:  tx_o = UartStopBit;
            default: tx_o = UartIdleLevel;
        endcase
    end

endmodule

// File: rtl/uart_packet_tx.sv
// Sends one 32-bit word per valid/ready handshake as four 8N1 bytes, LSB byte first.
// Define PKT_TX_CHECKSUM_EN to append an XOR checksum byte after byte 3.
module uart_packet_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
`ifdef PKT_TX_CHECKSUM_EN
    localparam logic [2:0] LastByte = 3'd4;
`else
    localparam logic [2:0] LastByte = 3'd3;
`endif

    logic [31:0] data_q, data_d;
    logic        active_q, active_d;
    logic        start_q, start_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic        done_q, done_d;
    logic        accept, byte_done, more, byte_start;
    logic [2:0]  sel_idx;
    logic [7:0]  byte_sel;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
        case (idx)
            3'd0:    return w[7:0];
            3'd1:    return w[15:8];
            3'd2:    return w[23:16];
            3'd3:    return w[31:24];
`ifdef PKT_TX_CHECKSUM_EN
            3'd4:    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`endif
            default: return 8'h00;
        endcase
    endfunction

    assign accept = valid && !active_q;
    assign more   = (byte_idx_q != LastByte);

    // The first byte is kicked off by start_q; later bytes are chained at stop-bit end.
    assign byte_start = start_q || (byte_done && more);
    assign sel_idx    = start_q ? 3'd0 : byte_idx_q + 3'd1;
    assign byte_sel   = pick_byte(data_q, sel_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            active_q   <= 1'b0;
            start_q    <= 1'b0;
            byte_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            data_q     <= data_d;
            active_q   <= active_d;
            start_q    <= start_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        data_d     = data_q;
        active_d   = active_q;
        start_d    = 1'b0;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        if (accept) begin
            data_d     = data;
            active_d   = 1'b1;
            start_d    = 1'b1;
            byte_idx_d = '0;
        end
        if (byte_done) begin
            if (more) begin
                byte_idx_d = byte_idx_q + 3'd1;
            end else begin
                active_d   = 1'b0;
                done_d     = 1'b1;
                byte_idx_d = '0;
            end
        end
    end

    uart_tx_byte #(
        .ClksPerBit(ClksPerBit)
    ) u_tx_byte (
        .clk_i      (clk),
        .rst_ni     (reset),
        .start_i    (byte_start),
        .byte_i     (byte_sel),
        .tx_o       (tx),
        .byte_done_o(byte_done)
    );

    assign ready = !active_q;
    assign busy  = active_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx at CLKS_PER_BIT=10: table-driven packets, directed corner
// sequences and random words checked against a byte-list line model.
module tb_uart_packet_tx;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned BAUD     = 100;
    localparam int          CPB      = 10;
`ifdef PKT_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        tx;

    uart_packet_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .data (data),
        .valid(valid),
        .ready(ready),
        .busy (busy),
        .done (done),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line bytes in transmission order, first byte in the top 8 bits; slot 4 is the checksum.
    typedef struct {
        logic [31:0] word;
        logic [39:0] line;
    } vec_t;

    vec_t tbl[6];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int fall_cyc = 0;
    int done_base = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    function automatic logic [39:0] model_line(input logic [31:0] w);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [39:0] r;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'((w >> (8 * i)) & 32'hFF));
            x = x ^ q[i];
        end
`ifdef PKT_TX_CHECKSUM_EN
        q.push_back(x);
`endif
        r = '0;
        for (int i = 0; i < q.size(); i++) begin
            r[39-8*i -: 8] = q[i];
        end
        return r;
    endfunction

    // Presents a word and steps across the accept edge; tx must still be idle-high.
    task automatic offer(input logic [31:0] w, input bit hold);
        data  = w;
        valid = 1'b1;
        tick();
        if (!hold) valid = 1'b0;
        check("accept busy", busy, 1);
        check("tx before fall", tx, 1);
    endtask

    task automatic expect_fall();
        tick();
        check("tx fall latency", tx, 0);
        fall_cyc  = cyc;
        done_base = done_cnt;
    endtask

    // Current sample is the first cycle of the start bit; every bit must hold for CPB cycles.
    task automatic recv(input logic [39:0] exp, input bit mid_change);
        for (int k = 0; k < NB; k++) begin
            logic [7:0] b;
            logic       v;
            bit         bad;
            b   = 8'h00;
            v   = 1'b0;
            bad = 1'b0;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (!(k == 0 && j == 0 && c == 0)) tick();
                    if (mid_change && k == 1 && j == 5 && c == 0) data = 32'hFFFF_FFFF;
                    if (c == 0) v = tx;
                    else if (tx !== v) bad = 1'b1;
                end
                if (j == 0 && v !== 1'b0) bad = 1'b1;
                if (j == 9 && v !== 1'b1) bad = 1'b1;
                if (j >= 1 && j <= 8) b[j-1] = v;
            end
            check($sformatf("line byte %0d", k), {bad, b}, {1'b0, exp[39-8*k -: 8]});
        end
    endtask

    task automatic expect_done();
        tick();
        check("done/ready/busy at end", {done, ready, busy}, 3'b110);
        check("packet duration", cyc - fall_cyc, NB * 10 * CPB);
        check("done pulse count", done_cnt - done_base, 1);
    endtask

    initial begin
        logic [31:0] w;
        bit          bad;

        reset = 1'b0;
        valid = 1'b0;
        data  = '0;

        tbl[0] = '{word: 32'h6B6C6363, line: 40'h63_63_6C_6B_07};
        tbl[1] = '{word: 32'h00430804, line: 40'h04_08_43_00_4F};
        tbl[2] = '{word: 32'h00432005, line: 40'h05_20_43_00_66};
        tbl[3] = '{word: 32'h31545352, line: 40'h52_53_54_31_64};
        tbl[4] = '{word: 32'h6E454D49, line: 40'h49_4D_45_6E_2F};
        tbl[5] = '{word: 32'hFFFFFFFF, line: 40'hFF_FF_FF_FF_00};

        repeat (3) tick();
        check("reset tx/ready/busy/done", {tx, ready, busy, done}, 4'b1100);
        reset = 1'b1;

        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({tx, ready, busy, done} !== 4'b1100) bad = 1'b1;
        end
        check("idle hold 100 cycles", bad, 0);

        for (int i = 0; i < 6; i++) begin
            offer(tbl[i].word, 1'b0);
            expect_fall();
            recv(tbl[i].line, 1'b0);
            expect_done();
        end

        // Back-to-back: second word accepted in the done cycle.
        tick();
        offer(tbl[1].word, 1'b0);
        expect_fall();
        recv(tbl[1].line, 1'b0);
        expect_done();
        offer(tbl[2].word, 1'b0);
        expect_fall();
        check("b2b fall after done", fall_cyc - last_done_cyc, 2);
        recv(tbl[2].line, 1'b0);
        expect_done();

        // valid held and data changed mid-packet; the done-cycle accept takes the new data.
        tick();
        offer(tbl[3].word, 1'b1);
        expect_fall();
        recv(tbl[3].line, 1'b1);
        expect_done();
        tick();
        valid = 1'b0;
        check("held-valid reaccept tx", tx, 1);
        expect_fall();
        recv(tbl[5].line, 1'b0);
        expect_done();

        // Reset during byte 1 data bits must clear outputs without a clock edge.
        tick();
        offer(tbl[0].word, 1'b0);
        expect_fall();
        repeat (133) tick();
        #1 reset = 1'b0;
        #1 check("async reset outputs", {tx, ready, busy, done}, 4'b1100);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("post-reset idle", {tx, ready, busy, done}, 4'b1100);
        offer(tbl[4].word, 1'b0);
        expect_fall();
        recv(tbl[4].line, 1'b0);
        expect_done();

        for (int r = 0; r < 4; r++) begin
            w = $urandom;
            offer(w, 1'b0);
            expect_fall();
            recv(model_line(w), 1'b0);
            expect_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
